// File: rtl/serial_word_rx_if.sv
// serial_word_rx_if: valid/ready word channel from the receiver to its consumer
interface serial_word_rx_if #(parameter int DATA_W = 16);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;
  modport master(output data, valid, input ready);
  modport slave(input data, valid, output ready);
endinterface

// File: rtl/serial_word_rx.sv
// serial_word_rx: framed serial word receiver with valid/ready word output
module serial_word_rx #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic [CNT_W-1:0]     clkdiv,
  serial_word_rx_if.master     out,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun
);
  localparam int BW = $clog2(DATA_W + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t            state;
  logic              rx_m, rx_s;
  logic [CNT_W-1:0]  cnt, div_l;
  logic [BW-1:0]     bitcnt;
  logic [DATA_W-1:0] sh;
  logic              tick;
  assign tick = cnt == '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      div_l     <= '0;
      bitcnt    <= '0;
      sh        <= '0;
      out.data  <= '0;
      out.valid <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_m      <= rx;
      rx_s      <= rx_m;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      // a same-edge delivery in STOP overrides this handshake clear
      if (out.valid && out.ready) out.valid <= 1'b0;
      if (state != IDLE && state != BRK) cnt <= tick ? div_l : cnt - 1'b1;
      case (state)
        IDLE: if (!rx_s) begin
          state <= START;
          busy  <= 1'b1;
          cnt   <= clkdiv >> 1;
          div_l <= clkdiv;
        end
        START: if (tick) begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state  <= DATA;
            bitcnt <= '0;
          end
        end
        DATA: if (tick) begin
          sh     <= {rx_s, sh[DATA_W-1:1]};
          bitcnt <= bitcnt + 1'b1;
          if (bitcnt == BW'(DATA_W - 1)) state <= STOP;
        end
        STOP: if (tick) begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (!out.valid || out.ready) begin
              out.data  <= sh;
              out.valid <= 1'b1;
            end else overrun <= 1'b1;
          end else begin
            frame_err <= 1'b1;
            state     <= BRK;
          end
        end
        BRK: if (rx_s) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_word_rx.sv
// tb_serial_word_rx: directed frames checked every cycle against a frame-level model
module tb_serial_word_rx;
  logic        clk = 1'b0, rst = 1'b1, rx = 1'b1;
  logic [15:0] clkdiv = 16'd3;
  logic        busy, frame_err, overrun;
  serial_word_rx_if #(.DATA_W(16)) bus();
  serial_word_rx #(.DATA_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .rx(rx), .clkdiv(clkdiv), .out(bus),
    .busy(busy), .frame_err(frame_err), .overrun(overrun)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0, cyc = 0;
  int          ev_c[$];
  logic [15:0] ev_w[$];
  bit          ev_ok[$];
  logic [15:0] m_data = '0;
  bit          m_valid = 0, m_ferr = 0, m_ovr = 0;
  int          rise_cyc, nrise, vcyc, nferr, novr, e0, start, stop;
  logic [15:0] rise_data;
  bit          busy_seen, pv = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic clr();
    nrise = 0; vcyc = 0; nferr = 0; novr = 0; busy_seen = 0;
  endtask
  // Drive one frame starting right after a negedge; the stop-sample edge is
  // predicted from the frame's latency: two synchroniser edges, then detection.
  task automatic frame(input logic [15:0] w, input bit stopb, input int nbits, output int first);
    int d = int'(clkdiv);
    first = cyc + 3;
    if (nbits == 16) begin
      ev_c.push_back(first + d / 2 + 1 + 17 * (d + 1));
      ev_w.push_back(w);
      ev_ok.push_back(stopb);
    end
    rx = 1'b0;
    repeat (d + 1) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      rx = w[i];
      repeat (d + 1) @(negedge clk);
    end
    if (nbits == 16) begin
      rx = stopb;
      repeat (d + 1) @(negedge clk);
      if (stopb) rx = 1'b1;
    end
  endtask
  always @(posedge clk) begin
    bit ev, ok;
    cyc++;
    m_ferr = 0;
    m_ovr  = 0;
    ev = ev_c.size() > 0 && ev_c[0] == cyc;
    ok = ev && ev_ok[0];
    if (rst) begin
      m_data  = '0;
      m_valid = 0;
    end else begin
      if (ev && !ev_ok[0]) m_ferr = 1;
      if (ok && (!m_valid || bus.ready)) begin
        m_data  = ev_w[0];
        m_valid = 1;
      end else if (ok) m_ovr = 1;
      else if (m_valid && bus.ready) m_valid = 0;
    end
    if (ev) begin
      void'(ev_c.pop_front());
      void'(ev_w.pop_front());
      void'(ev_ok.pop_front());
    end
    #1;
    chk("out_valid", bus.valid, m_valid);
    chk("out_data", bus.data, m_data);
    chk("frame_err", frame_err, m_ferr);
    chk("overrun", overrun, m_ovr);
    if (bus.valid && !pv) begin
      rise_cyc  = cyc;
      rise_data = bus.data;
      nrise++;
    end
    pv = bus.valid;
    if (bus.valid) vcyc++;
    if (frame_err) nferr++;
    if (overrun) novr++;
    if (busy) busy_seen = 1;
  end
  initial begin
    bus.ready = 1'b1;
    clr();
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    clr();
    clkdiv = 16'd3;
    frame(16'hA5C3, 1, 16, e0);
    repeat (6) @(negedge clk);
    chk("t1_rise_ofs", rise_cyc - e0, 70);
    chk("t1_data", rise_data, 16'hA5C3);
    chk("t1_width", vcyc, 1);
    chk("t1_nrise", nrise, 1);
    chk("t1_busy", busy, 0);
    chk("t1_model", m_data, 16'hA5C3);
    bus.ready = 1'b0;
    clr();
    frame(16'h0001, 1, 16, e0);
    repeat (3) @(negedge clk);
    frame(16'hFFFF, 1, 16, e0);
    repeat (6) @(negedge clk);
    chk("t2_overrun_cnt", novr, 1);
    chk("t2_data", bus.data, 16'h0001);
    chk("t2_valid", bus.valid, 1);
    chk("t2_model", m_data, 16'h0001);
    bus.ready = 1'b1;
    @(negedge clk);
    chk("t2_consumed", bus.valid, 0);
    clr();
    frame(16'h1234, 0, 16, e0);
    repeat (20) @(negedge clk);
    chk("t3_busy_break", busy, 1);
    repeat (20) @(negedge clk);
    chk("t3_busy_low_line", busy, 1);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    chk("t3_busy_idle", busy, 0);
    chk("t3_ferr_cnt", nferr, 1);
    chk("t3_no_valid", nrise, 0);
    clr();
    frame(16'h5555, 1, 16, e0);
    repeat (6) @(negedge clk);
    chk("t3_data", rise_data, 16'h5555);
    chk("t3_nrise", nrise, 1);
    chk("t3_no_ferr", nferr, 0);
    clkdiv = 16'd7;
    clr();
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("t4_busy_seen", busy_seen, 1);
    chk("t4_busy", busy, 0);
    chk("t4_no_valid", nrise, 0);
    chk("t4_no_ferr", nferr, 0);
    clkdiv = 16'd3;
    bus.ready = 1'b0;
    clr();
    frame(16'h00AA, 1, 16, e0);
    repeat (3) @(negedge clk);
    start = cyc;
    stop  = start + 73;
    fork
      frame(16'h00BB, 1, 16, e0);
      begin
        repeat (stop - 1 - start) @(negedge clk);
        bus.ready = 1'b1;
        @(negedge clk);
        bus.ready = 1'b0;
      end
    join
    repeat (6) @(negedge clk);
    chk("t5_no_overrun", novr, 0);
    chk("t5_data", bus.data, 16'h00BB);
    chk("t5_valid", bus.valid, 1);
    chk("t5_nrise", nrise, 1);
    bus.ready = 1'b1;
    clr();
    frame(16'hBEEF, 1, 6, e0);
    rst = 1'b1;
    rx  = 1'b1;
    #1;
    chk("t6_rst_valid", bus.valid, 0);
    chk("t6_rst_data", bus.data, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_flags", {frame_err, overrun}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    frame(16'hCAFE, 1, 16, e0);
    repeat (6) @(negedge clk);
    chk("t6_nrise", nrise, 1);
    chk("t6_data", rise_data, 16'hCAFE);
    chk("t6_busy", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
